// File: rtl/note_sequencer.sv
// Song-playback sequencer: walks a note ROM and times each note and the silent gap after it in ms.
// Optional build macro NOTE_SEQ_LOOP_EN: the end marker restarts the table instead of ending playback.
module note_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int GAP_MS      = 20,
    parameter int DUR_UNIT_MS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ticks_per_milli,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [5:0]        note_code,
    output logic              note_valid,
    output logic              ms_tick,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = 16;
    localparam logic [5:0] END_MARK = 6'd63;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [5:0]         pitch_reg, pitch_next;
    logic [CNT_W-1:0]   ms_cnt_reg, ms_cnt_next;
    logic [15:0]        presc_reg, presc_next;
    logic [5:0]         note_code_reg, note_code_next;
    logic               note_valid_reg, note_valid_next;
    logic               ms_tick_reg, ms_tick_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [15:0]        t_last;
    logic               timing;
    logic               tick_now;
    logic [5:0]         rom_pitch;
    logic [5:0]         rom_dur;
    logic [CNT_W-1:0]   dur_ms;
    logic [ADDR_W-1:0]  addr_inc;
    logic               timing_next;

    assign t_last    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign timing    = (state_reg == S_PLAY) || (state_reg == S_GAP);
    // >= rather than == so a shrinking ticks_per_milli cannot strand the prescaler above the new limit
    assign tick_now  = timing && (presc_reg >= t_last);
    assign rom_pitch = rom_data[11:6];
    assign rom_dur   = rom_data[5:0];
    assign dur_ms    = CNT_W'(32'(rom_dur) * 32'(DUR_UNIT_MS));
    assign addr_inc  = addr_reg + ADDR_W'(1);

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        pitch_next  = pitch_reg;
        ms_cnt_next = ms_cnt_reg;
        presc_next  = tick_now ? 16'd0 : (timing ? presc_reg + 16'd1 : 16'd0);
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                addr_next = '0;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                pitch_next = rom_pitch;
                if (rom_pitch == END_MARK) begin
                    addr_next = '0;
`ifdef NOTE_SEQ_LOOP_EN
                    state_next = S_FETCH;
`else
                    state_next = S_IDLE;
                    done_next  = 1'b1;
`endif
                end else if (rom_dur == 6'd0) begin
                    addr_next = addr_inc;
                end else begin
                    ms_cnt_next = dur_ms;
                    presc_next  = 16'd0;
                    state_next  = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_now) begin
                    if (ms_cnt_reg <= CNT_W'(1)) begin
                        if (GAP_MS > 0) begin
                            ms_cnt_next = CNT_W'(GAP_MS);
                            presc_next  = 16'd0;
                            state_next  = S_GAP;
                        end else begin
                            addr_next  = addr_inc;
                            state_next = S_FETCH;
                        end
                    end else begin
                        ms_cnt_next = ms_cnt_reg - CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick_now) begin
                    if (ms_cnt_reg <= CNT_W'(1)) begin
                        addr_next  = addr_inc;
                        state_next = S_FETCH;
                    end else begin
                        ms_cnt_next = ms_cnt_reg - CNT_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (stop) begin
            state_next  = S_IDLE;
            addr_next   = '0;
            ms_cnt_next = '0;
            presc_next  = 16'd0;
            done_next   = 1'b0;
        end
    end

    // Outputs are derived from the next state so every port comes straight off a flop
    always_comb begin
        timing_next     = (state_next == S_PLAY) || (state_next == S_GAP);
        note_code_next  = (state_next == S_PLAY) ? pitch_next : 6'd0;
        note_valid_next = (state_next == S_PLAY) && (pitch_next != 6'd0);
        busy_next       = (state_next != S_IDLE);
        ms_tick_next    = timing_next && (presc_next >= t_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            pitch_reg      <= '0;
            ms_cnt_reg     <= '0;
            presc_reg      <= '0;
            note_code_reg  <= '0;
            note_valid_reg <= 1'b0;
            ms_tick_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            pitch_reg      <= pitch_next;
            ms_cnt_reg     <= ms_cnt_next;
            presc_reg      <= presc_next;
            note_code_reg  <= note_code_next;
            note_valid_reg <= note_valid_next;
            ms_tick_reg    <= ms_tick_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign rom_addr   = addr_reg;
    assign note_code  = note_code_reg;
    assign note_valid = note_valid_reg;
    assign ms_tick    = ms_tick_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: captures per-cycle output traces after each start and checks timing.
module tb_note_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic        start;
    logic        stop;
    logic [4:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_code;
    logic        note_valid;
    logic        ms_tick;
    logic        busy;
    logic        done;

    logic [11:0] rom [32];
    assign rom_data = rom[rom_addr];

    note_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .start           (start),
        .stop            (stop),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .note_code       (note_code),
        .note_valid      (note_valid),
        .ms_tick         (ms_tick),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       v_a [0:1399];
    logic [5:0] c_a [0:1399];
    logic [4:0] a_a [0:1399];
    logic       b_a [0:1399];
    logic       d_a [0:1399];
    logic       t_a [0:1399];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Sample index i is the i-th falling edge after the start pulse was launched
    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            v_a[i] = note_valid;
            c_a[i] = note_code;
            a_a[i] = rom_addr;
            b_a[i] = busy;
            d_a[i] = done;
            t_a[i] = ms_tick;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic int first_valid(input int n);
        for (int i = 1; i <= n; i++) if (v_a[i]) return i;
        return -1;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 1; i <= n; i++) if (d_a[i]) return i;
        return -1;
    endfunction

    function automatic int cnt_valid(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (v_a[i]) c++;
        return c;
    endfunction

    function automatic int cnt_busy(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (b_a[i]) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (d_a[i]) c++;
        return c;
    endfunction

    function automatic int cnt_tick(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (t_a[i]) c++;
        return c;
    endfunction

    function automatic int cnt_nz(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (c_a[i] != 6'd0 || a_a[i] != 5'd0) c++;
        return c;
    endfunction

    task automatic fill_end();
        for (int i = 0; i < 32; i++) rom[i] = {6'd63, 6'd0};
    endtask

    int fv;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        ticks_per_milli = 16'd4;
        fill_end();
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({note_code, note_valid, ms_tick, busy, done, rom_addr}), 0);
        rst = 1'b0;

        // idle with start low
        capture(100);
        check("idle_busy", cnt_busy(100), 0);
        check("idle_valid", cnt_valid(100), 0);
        check("idle_done", cnt_done(100), 0);
        check("idle_tick", cnt_tick(100), 0);
        check("idle_code_addr", cnt_nz(100), 0);

        // single note, T=4: FETCH 1, PLAY 128, GAP 80, FETCH end, done
        rom[0] = {6'd10, 6'd2};
        pulse_start();
        capture(260);
        fv = first_valid(260);
        check("t1_first_valid", fv, 2);
        check("t1_code", (fv > 0) ? int'(c_a[fv]) : -1, 10);
        check("t1_valid_len", cnt_valid(260), 128);
        check("t1_busy_len", cnt_busy(260), 210);
        check("t1_done_idx", first_done(260), 211);
        check("t1_done_cnt", cnt_done(260), 1);
        check("t1_busy_at_done", int'(b_a[211]), 0);
        check("t1_busy_before_done", int'(b_a[210]), 1);
        check("t1_ms_ticks", cnt_tick(260), 52);

        // rest, skipped entry, then note 7
        fill_end();
        rom[0] = {6'd0, 6'd1};
        rom[1] = {6'd5, 6'd0};
        rom[2] = {6'd7, 6'd1};
        pulse_start();
        capture(320);
        check("t2_rest_valid", int'(v_a[30]), 0);
        check("t2_rest_code", int'(c_a[30]), 0);
        check("t2_rest_busy", int'(b_a[30]), 1);
        check("t2_skip_addr1", int'(a_a[146]), 1);
        check("t2_skip_addr2", int'(a_a[147]), 2);
        fv = first_valid(320);
        check("t2_first_valid", fv, 148);
        check("t2_code", (fv > 0) ? int'(c_a[fv]) : -1, 7);
        check("t2_valid_len", cnt_valid(320), 64);
        check("t2_done_idx", first_done(320), 293);

        // stop in the middle of PLAY
        fill_end();
        rom[0] = {6'd10, 6'd2};
        pulse_start();
        capture(49);
        check("t3_playing", int'(v_a[49]), 1);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("t3_stop_valid", int'(note_valid), 0);
        check("t3_stop_busy", int'(busy), 0);
        check("t3_stop_code", int'(note_code), 0);
        capture(300);
        check("t3_after_done", cnt_done(300), 0);
        check("t3_after_busy", cnt_busy(300), 0);

        // start and stop together from IDLE
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        capture(10);
        check("t3_start_stop_busy", cnt_busy(10), 0);

        // full table, no end marker, T=0 -> 37 cycles per note
        ticks_per_milli = 16'd0;
        for (int i = 0; i < 32; i++) rom[i] = {6'(i + 1), 6'd1};
        pulse_start();
        capture(1190);
        check("t4_addr31", int'(a_a[1148]), 31);
        check("t4_code32", int'(c_a[1149]), 32);
        check("t4_wrap_addr", int'(a_a[1185]), 0);
        check("t4_wrap_code", int'(c_a[1186]), 1);
        check("t4_wrap_valid", int'(v_a[1186]), 1);
        check("t4_no_done", cnt_done(1190), 0);
        check("t4_busy", cnt_busy(1190), 1190);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);

        // T=0 single note {3 D=1, end}: PLAY 16 cycles
        fill_end();
        rom[0] = {6'd3, 6'd1};
        pulse_start();
        capture(200);
        check("t5_first_valid", first_valid(200), 2);
        check("t5_code", int'(c_a[2]), 3);
        check("t5_play_end", int'(v_a[17]), 1);
        check("t5_gap_start", int'(v_a[18]), 0);
`ifdef NOTE_SEQ_LOOP_EN
        check("t5_loop_busy", int'(b_a[39]), 1);
        check("t5_loop_code", int'(c_a[40]), 3);
        check("t5_loop_valid", int'(v_a[40]), 1);
        check("t5_loop_no_done", cnt_done(200), 0);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
`else
        check("t5_valid_len", cnt_valid(200), 16);
        check("t5_done_idx", first_done(200), 39);
        check("t5_ms_ticks", cnt_tick(200), 36);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
